// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store initiator for a word-organised synchronous data memory.
// Byte stores are done as read-modify-write because the memory only writes whole words.
module mem_access_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_MemWrite,
    input  logic [31:0] mem_RD
);
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

    state_t      state;
    logic        wr_q;
    logic        byte_q;
    logic [1:0]  lane;
    logic [7:0]  wbyte;
    logic        bad;
    logic [4:0]  sh;
    logic [31:0] lane_rd;
    logic [31:0] merged;

    always_comb begin
        bad     = (!req_byte && req_addr[1:0] != 2'b00) || req_addr >= 32'(MEM_BYTES);
        sh      = {lane, 3'b000};
        lane_rd = (mem_RD >> sh) & 32'h0000_00ff;
        merged  = (mem_RD & ~(32'h0000_00ff << sh)) | ({24'b0, wbyte} << sh);
    end

    assign req_ready    = state == IDLE;
    // Gated by rst_n so a reset edge can never commit a half-finished store.
    assign mem_MemWrite = state == WR && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_A      <= '0;
            mem_WD     <= '0;
            wr_q       <= 1'b0;
            byte_q     <= 1'b0;
            lane       <= '0;
            wbyte      <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    wr_q   <= req_write;
                    byte_q <= req_byte;
                    lane   <= req_addr[1:0];
                    wbyte  <= req_wdata[7:0];
                    mem_A  <= {req_addr[31:2], 2'b00};
                    mem_WD <= req_wdata;
                    if (bad) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        state <= req_write && !req_byte ? WR : RD;
                    end
                end
                RD: state <= RDW;
                RDW: if (wr_q) begin
                    mem_WD <= merged;
                    state  <= WR;
                end else begin
                    resp_rdata <= byte_q ? lane_rd : mem_RD;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a registered-read word memory model behind the unit.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_MemWrite;
    logic [31:0] mem_RD;

    mem_access_unit #(.MEM_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_MemWrite(mem_MemWrite), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023] = '{default: 32'h0};
    int          wr_cnt = 0;
    int          reset_wr = 0;
    logic [31:0] last_wd = 32'h0;
    int          cyc = 0;
    int          accepts = 0;
    int          acc_t[$];
    int          dbl = 0;
    logic        prev_rv = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) begin
        cyc++;
        if (mem_MemWrite) begin
            mem[mem_A[11:2]] <= mem_WD;
            wr_cnt++;
            last_wd = mem_WD;
            if (!rst_n) reset_wr++;
        end
        mem_RD <= mem[mem_A[11:2]];
        if (rst_n && req_valid && req_ready) begin
            accepts++;
            acc_t.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (resp_valid && prev_rv) dbl++;
        prev_rv = resp_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, input int lat, input logic [31:0] er, input logic ee);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " rdata"}, resp_rdata, er);
        check({tag, " err"}, 32'(resp_err), 32'(ee));
        @(posedge clk); #1;
        check({tag, " pulse"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_rdata"}, resp_rdata, 32'd0);
        check({tag, " resp_err"}, 32'(resp_err), 32'd0);
        check({tag, " mem_A"}, mem_A, 32'd0);
        check({tag, " mem_WD"}, mem_WD, 32'd0);
        check({tag, " mem_MemWrite"}, 32'(mem_MemWrite), 32'd0);
    endtask

    logic [31:0] bl_exp [4];
    logic [31:0] ref_m [logic [31:0]];
    logic [31:0] sa, sd, se;
    logic        sw;
    int          n, w0, base, acc0;

    initial begin
        bl_exp = '{32'h44, 32'h33, 32'hAA, 32'h11};
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        check("reset ready", 32'(req_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        do_req("wst10", 1, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0);
        do_req("wld10", 0, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0);

        do_req("wst20", 1, 0, 32'h20, 32'h11223344, 2, 32'h0, 0);
        w0 = wr_cnt;
        do_req("bst22", 1, 1, 32'h22, 32'h000055AA, 4, 32'h0, 0);
        check("bst22 writes", 32'(wr_cnt - w0), 32'd1);
        check("bst22 wdata", last_wd, 32'h11AA3344);
        do_req("wld20", 0, 0, 32'h20, 32'h0, 3, 32'h11AA3344, 0);
        for (int i = 0; i < 4; i++)
            do_req($sformatf("bld2%0d", i), 0, 1, 32'h20 + 32'(i), 32'h0, 3, bl_exp[i], 0);

        w0 = wr_cnt;
        do_req("err_wld21", 0, 0, 32'h21, 32'h0, 1, 32'h0, 1);
        do_req("err_wst1000", 1, 0, 32'h1000, 32'h12345678, 1, 32'h0, 1);
        do_req("err_bld1003", 0, 1, 32'h1003, 32'h0, 1, 32'h0, 1);
        do_req("ok_bldfff", 0, 1, 32'hFFF, 32'h0, 3, 32'h0, 0);
        check("err writes", 32'(wr_cnt - w0), 32'd0);
        check("err mem0", mem[0], 32'h0);
        check("err mem20", mem[8], 32'h11AA3344);

        do_req("wst30", 1, 0, 32'h30, 32'hCAFEF00D, 2, 32'h0, 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
            req_addr = 32'h31; req_wdata = 32'h77;
            @(posedge clk);
            #1 req_valid = 1'b0;
            repeat (k) begin @(posedge clk); #1; end
            if (k == 2) check("rmw in WR", 32'(mem_MemWrite), 32'd1);
            rst_n = 1'b0;
            #1;
            check($sformatf("rst%0d we gated", k), 32'(mem_MemWrite), 32'd0);
            @(posedge clk); #1;
            check_zero($sformatf("rst%0d", k));
            rst_n = 1'b1;
            check($sformatf("rst%0d ready", k), 32'(req_ready), 32'd1);
        end
        check("reset writes", 32'(reset_wr), 32'd0);
        check("mem30 kept", mem[12], 32'hCAFEF00D);
        do_req("wld30", 0, 0, 32'h30, 32'h0, 3, 32'hCAFEF00D, 0);

        base = acc_t.size();
        acc0 = accepts;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sw = i % 2 == 0;
            sa = 32'h40 + 32'(4 * (i / 2));
            sd = 32'hA5000000 + 32'(i * 32'h00010203);
            @(negedge clk);
            n = 0;
            while (!req_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            req_write = sw; req_byte = 1'b0; req_addr = sa; req_wdata = sd;
            if (sw) ref_m[sa] = sd;
            se = sw ? 32'h0 : ref_m[sa];
            @(posedge clk); #1;
            n = 1;
            while (!resp_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("stream%0d latency", i), 32'(n), sw ? 32'd2 : 32'd3);
            check($sformatf("stream%0d rdata", i), resp_rdata, se);
        end
        req_valid = 1'b0;
        check("stream accepts", 32'(accepts - acc0), 32'd6);
        for (int i = 1; i < 6 && base + i < acc_t.size(); i++)
            check($sformatf("stream gap%0d", i), 32'(acc_t[base + i] - acc_t[base + i - 1]),
                  (i % 2 == 1) ? 32'd3 : 32'd4);
        repeat (3) @(posedge clk);
        check("resp pulse width", 32'(dbl), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
